// File: rtl/pad_scanner.sv
// Joystick scanner: synchronises MiST joystick bits, optionally swaps channels 0/1,
// debounces each channel, adds autofire on fire1 and emits active-low pad bytes.
module pad_scanner #(
   parameter int NUM_PADS     = 2,
   parameter int DEBOUNCE     = 15,
   parameter int AUTOFIRE_DIV = 50000
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [8*NUM_PADS-1:0] joy_in,
   input  logic [NUM_PADS-1:0]   autofire_en,
   input  logic                  swap,
   output logic [8*NUM_PADS-1:0] pad_out,
   output logic [NUM_PADS-1:0]   pad_chg
);

   localparam int CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
   localparam int PW = $clog2(AUTOFIRE_DIV);
   localparam logic [CW-1:0] CNT_LAST = CW'((DEBOUNCE > 0) ? DEBOUNCE - 1 : 0);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [PW-1:0] PH_LAST  = PW'(AUTOFIRE_DIV - 1);
   localparam logic [PW-1:0] PH_ONE   = PW'(1);

   typedef enum logic [1:0] {
      AF_IDLE = 2'd0,
      AF_ON   = 2'd1,
      AF_OFF  = 2'd2
   } af_state_t;

   logic [7*NUM_PADS-1:0] joy_bits_s;
   logic [7*NUM_PADS-1:0] sync1_r;
   logic [7*NUM_PADS-1:0] sync2_r;
   logic [7*NUM_PADS-1:0] post_s;
   logic [NUM_PADS-1:0]   unused_bit7_s;

   // Gather the seven live bits of every channel; bit7 carries nothing
   always_comb begin
      joy_bits_s    = '0;
      unused_bit7_s = '0;
      for (int i = 0; i < NUM_PADS; i++) begin
         joy_bits_s[7*i +: 7] = joy_in[8*i +: 7];
         unused_bit7_s[i]     = joy_in[8*i + 7];
      end
   end

   // Two-flop synchroniser on every live joystick bit
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_r <= '0;
         sync2_r <= '0;
      end else begin
         sync1_r <= joy_bits_s;
         sync2_r <= sync1_r;
      end
   end

   generate
      if (NUM_PADS >= 2) begin : g_swap
         // Swap is applied to synchronised data so the debouncers see it as an input change
         always_comb begin
            post_s = sync2_r;
            if (swap) begin
               post_s[6:0]  = sync2_r[13:7];
               post_s[13:7] = sync2_r[6:0];
            end else begin
               post_s = sync2_r;
            end
         end
      end else begin : g_noswap
         logic unused_swap_s;
         assign unused_swap_s = swap;
         assign post_s        = sync2_r;
      end
   endgenerate

   generate
      for (genvar g = 0; g < NUM_PADS; g++) begin : g_ch
         logic [6:0]    cur_s;
         logic [6:0]    prev_r;
         logic [6:0]    comm_r;
         logic [6:0]    comm_next_s;
         logic [CW-1:0] cnt_r;
         logic [CW-1:0] cnt_next_s;
         logic          commit_s;
         af_state_t     state_r;
         af_state_t     state_next_s;
         logic [PW-1:0] phase_r;
         logic [PW-1:0] phase_next_s;
         logic          fire_eff_s;
         logic          up_s;
         logic          down_s;
         logic          left_s;
         logic          right_s;
         logic [7:0]    byte_next_s;
         logic [7:0]    out_r;
         logic          chg_r;

         assign cur_s = post_s[7*g +: 7];

         // Debouncer: commit once a differing value has stayed put long enough
         always_comb begin
            cnt_next_s = '0;
            commit_s   = 1'b0;
            if (cur_s == comm_r) begin
               cnt_next_s = '0;
            end else if (DEBOUNCE == 0) begin
               commit_s = 1'b1;
            end else if (cur_s != prev_r) begin
               cnt_next_s = '0;
            end else if (cnt_r == CNT_LAST) begin
               commit_s = 1'b1;
            end else begin
               cnt_next_s = cnt_r + CNT_ONE;
            end
            comm_next_s = commit_s ? cur_s : comm_r;
         end

         // Autofire next state; it looks at the value being committed this cycle
         // so a fire1 release reaches pad_out with the normal pipeline latency
         always_comb begin
            state_next_s = state_r;
            phase_next_s = phase_r;
            if (!comm_next_s[4] || !autofire_en[g]) begin
               state_next_s = AF_IDLE;
               phase_next_s = '0;
            end else begin
               case (state_r)
                  AF_IDLE: begin
                     state_next_s = AF_ON;
                     phase_next_s = '0;
                  end
                  AF_ON: begin
                     if (phase_r == PH_LAST) begin
                        state_next_s = AF_OFF;
                        phase_next_s = '0;
                     end else begin
                        phase_next_s = phase_r + PH_ONE;
                     end
                  end
                  AF_OFF: begin
                     if (phase_r == PH_LAST) begin
                        state_next_s = AF_ON;
                        phase_next_s = '0;
                     end else begin
                        phase_next_s = phase_r + PH_ONE;
                     end
                  end
                  default: begin
                     state_next_s = AF_IDLE;
                     phase_next_s = '0;
                  end
               endcase
            end
         end

         // Output byte: opposing axis bits cancel, then everything is inverted
         always_comb begin
            case (state_next_s)
               AF_ON:   fire_eff_s = 1'b1;
               AF_OFF:  fire_eff_s = 1'b0;
               default: fire_eff_s = comm_next_s[4];
            endcase
            up_s        = comm_next_s[3] & ~comm_next_s[2];
            down_s      = comm_next_s[2] & ~comm_next_s[3];
            right_s     = comm_next_s[0] & ~comm_next_s[1];
            left_s      = comm_next_s[1] & ~comm_next_s[0];
            byte_next_s = ~{comm_next_s[6], comm_next_s[5], fire_eff_s, 1'b0,
                            up_s, down_s, right_s, left_s};
         end

         // Channel state and registered outputs
         always_ff @(posedge clk) begin
            if (reset) begin
               prev_r  <= 7'd0;
               comm_r  <= 7'd0;
               cnt_r   <= '0;
               state_r <= AF_IDLE;
               phase_r <= '0;
               out_r   <= 8'hFF;
               chg_r   <= 1'b0;
            end else begin
               prev_r  <= cur_s;
               comm_r  <= comm_next_s;
               cnt_r   <= cnt_next_s;
               state_r <= state_next_s;
               phase_r <= phase_next_s;
               out_r   <= byte_next_s;
               chg_r   <= (byte_next_s != out_r);
            end
         end

         assign pad_out[8*g +: 8] = out_r;
         assign pad_chg[g]        = chg_r;
      end
   endgenerate

endmodule

// File: tb/tb_pad_scanner.sv
// Self-checking bench for pad_scanner: a cycle model built from the joystick rules
// runs alongside the DUT, plus directed scenarios with literal expectations.
module tb_pad_scanner;
   localparam int NP  = 2;
   localparam int D   = 15;
   localparam int DIV = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] joy_in;
   logic [1:0]  autofire_en;
   logic        swap;
   logic [15:0] pad_out;
   logic [1:0]  pad_chg;

   pad_scanner #(.NUM_PADS(NP), .DEBOUNCE(D), .AUTOFIRE_DIV(DIV)) dut (
      .clk(clk), .reset(reset), .joy_in(joy_in), .autofire_en(autofire_en),
      .swap(swap), .pad_out(pad_out), .pad_chg(pad_chg)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   bit chk_en = 1'b0;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Direction from signed axes (x: right minus left, y: up minus down)
   function automatic logic [7:0] enc(input logic [6:0] b, input logic f1);
      int x, y;
      logic [4:0] code;
      x = int'(b[0]) - int'(b[1]);
      y = int'(b[3]) - int'(b[2]);
      case ((y + 1) * 3 + (x + 1))
         0: code = 5'b00101;
         1: code = 5'b00100;
         2: code = 5'b00110;
         3: code = 5'b00001;
         4: code = 5'b00000;
         5: code = 5'b00010;
         6: code = 5'b01001;
         7: code = 5'b01000;
         8: code = 5'b01010;
         default: code = 5'b00000;
      endcase
      return ~{b[6], b[5], f1, code};
   endfunction

   logic [6:0]  d1[NP], d2[NP], last[NP], comm[NP], post[NP];
   int          run[NP], mode[NP], ph[NP];
   logic [15:0] exp_out = 16'hFFFF;
   logic [1:0]  exp_chg = 2'b00;
   logic        fire;
   logic [7:0]  nb;

   // Model: inputs are seen two cycles late, committed after D+1 identical samples
   always @(posedge clk) begin
      if (reset) begin
         for (int c = 0; c < NP; c++) begin
            d1[c] = 7'd0; d2[c] = 7'd0; last[c] = 7'd0; comm[c] = 7'd0;
            run[c] = 0; mode[c] = 0; ph[c] = 0;
         end
         exp_out = 16'hFFFF;
         exp_chg = 2'b00;
      end else begin
         for (int c = 0; c < NP; c++) post[c] = swap ? d2[1-c] : d2[c];
         for (int c = 0; c < NP; c++) begin
            if (post[c] == last[c]) begin
               if (run[c] < 1000) run[c]++;
            end else begin
               run[c] = 1;
            end
            last[c] = post[c];
            if (post[c] != comm[c] && run[c] >= D + 1) comm[c] = post[c];
            if (!comm[c][4] || !autofire_en[c]) begin
               mode[c] = 0; ph[c] = 0;
            end else if (mode[c] == 0) begin
               mode[c] = 1; ph[c] = 0;
            end else if (ph[c] == DIV - 1) begin
               mode[c] = 3 - mode[c]; ph[c] = 0;
            end else begin
               ph[c]++;
            end
            fire = (mode[c] == 1) ? 1'b1 : (mode[c] == 2) ? 1'b0 : comm[c][4];
            nb = enc(comm[c], fire);
            exp_chg[c] = (nb != exp_out[8*c +: 8]);
            exp_out[8*c +: 8] = nb;
         end
         for (int c = 0; c < NP; c++) begin
            d2[c] = d1[c];
            d1[c] = joy_in[8*c +: 7];
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("cyc_pad_out", pad_out, exp_out);
         check("cyc_pad_chg", {14'd0, pad_chg}, {14'd0, exp_chg});
      end
   end

   initial begin
      reset = 1'b1; joy_in = 16'h0000; autofire_en = 2'b00; swap = 1'b0;
      tick(3);
      chk_en = 1'b1;
      check("reset_out", pad_out, 16'hFFFF);
      check("reset_chg", {14'd0, pad_chg}, 16'h0000);
      reset = 1'b0;
      tick(5);

      // Latency: up on channel 0
      joy_in = 16'h0008;
      tick(17); check("lat_before", pad_out, 16'hFFFF);
      tick(1);  check("lat_f7", pad_out, 16'hFFF7);
      check("lat_chg", {14'd0, pad_chg}, 16'h0001);
      check("model_f7", exp_out, 16'hFFF7);
      tick(1);  check("lat_chg_once", {14'd0, pad_chg}, 16'h0000);
      joy_in = 16'h0000; tick(20); check("lat_release", pad_out, 16'hFFFF);

      // Glitch shorter than the debounce window
      joy_in = 16'h0001; tick(10);
      joy_in = 16'h0000; tick(20); check("glitch", pad_out, 16'hFFFF);

      // Axis cancel
      joy_in = 16'h000F; tick(20); check("cancel_all", pad_out, 16'hFFFF);
      joy_in = 16'h000B; tick(20); check("cancel_lr", pad_out, 16'hFFF7);
      joy_in = 16'h0000; tick(20);

      // Both channels together
      joy_in = 16'h265A;
      tick(17); check("both_before", pad_out, 16'hFFFF);
      tick(1);  check("both_out", pad_out, 16'hBA56);
      check("both_chg", {14'd0, pad_chg}, 16'h0003);
      check("model_both", exp_out, 16'hBA56);
      joy_in = 16'h0000; tick(20); check("both_release", pad_out, 16'hFFFF);

      // Autofire with a 4-cycle half period
      autofire_en = 2'b01; joy_in = 16'h0010;
      tick(18); check("af_on0", pad_out, 16'hFFDF);
      tick(3);  check("af_on3", pad_out, 16'hFFDF);
      tick(1);  check("af_off0", pad_out, 16'hFFFF);
      check("model_af_off", exp_out, 16'hFFFF);
      tick(4);  check("af_on_again", pad_out, 16'hFFDF);
      tick(1);
      reset = 1'b1; tick(1); check("af_reset", pad_out, 16'hFFFF);
      reset = 1'b0;
      tick(17); check("af_rst_before", pad_out, 16'hFFFF);
      tick(1);  check("af_recommit", pad_out, 16'hFFDF);
      tick(3);  check("af_rst_on3", pad_out, 16'hFFDF);
      tick(1);  check("af_rst_off", pad_out, 16'hFFFF);
      joy_in = 16'h0000; tick(D + 3); check("af_release", pad_out, 16'hFFFF);
      autofire_en = 2'b00; tick(5);

      // Swap channels 0 and 1
      swap = 1'b1; joy_in = 16'h0010;
      tick(20); check("swap_on", pad_out, 16'hDFFF);
      swap = 1'b0;
      tick(20); check("swap_off", pad_out, 16'hFFDF);
      joy_in = 16'h0000; tick(20); check("swap_release", pad_out, 16'hFFFF);

      // Reset in the middle of a debounce
      joy_in = 16'h0008; tick(10);
      reset = 1'b1; tick(1); reset = 1'b0;
      tick(17); check("mid_rst_before", pad_out, 16'hFFFF);
      tick(1);  check("mid_rst_commit", pad_out, 16'hFFF7);
      joy_in = 16'h0000; tick(20);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/pad_scanner.md
PAD_SCANNER -- requirements
Module: pad_scanner

Interface
REQ-001 Parameter NUM_PADS, default 2: number of joystick channels, legal range 1..4.
REQ-002 Parameter DEBOUNCE, default 15: number of stable cycles required before a change is committed; 0 disables debounce.
REQ-003 Parameter AUTOFIRE_DIV, default 50000: autofire half-period in clk cycles; legal range >= 2.
REQ-004 clk  input  1  single clock for all logic.
REQ-005 reset  input  1  synchronous, active-high reset sampled on rising clk.
REQ-006 joy_in  input  8*NUM_PADS  MiST joystick bits per channel i at [8i+7:8i]: bit0 right, bit1 left, bit2 down, bit3 up, bit4 fire1, bit5 fire2, bit6 fire3; bit7 is ignored.
REQ-007 autofire_en  input  NUM_PADS  per-channel autofire enable on fire1; may change at any time.
REQ-008 swap  input  1  when 1 and NUM_PADS >= 2, channel 0 input drives output channel 1 and channel 1 input drives output channel 0.
REQ-009 pad_out  output  8*NUM_PADS  active-low hand-controller byte per channel, registered.
REQ-010 pad_chg  output  NUM_PADS  one-cycle pulse when the corresponding pad_out byte changes value.

Function
REQ-011 Each joy_in bit SHALL pass through a 2-flop synchroniser before any further use.
REQ-012 swap SHALL be applied after the synchronisers; channels >= 2 are unaffected; a swap change SHALL be treated like an input change by the debouncers.
REQ-013 Per channel, a debouncer SHALL hold a committed 7-bit state and a counter; a synchronised value that differs from the committed state and stays constant for DEBOUNCE consecutive cycles SHALL be committed; any change during counting SHALL restart the counter at 0.
REQ-014 Latency: a joy_in change held stable SHALL appear on pad_out exactly DEBOUNCE+3 clk cycles later (3 cycles when DEBOUNCE=0).
REQ-015 Axis cancel: if up and down are both committed, neither is encoded; the same rule applies to left and right.
REQ-016 Direction code, active-high bits[4:0] before inversion: none 00000, up 01000, up-right 01010, right 00010, down-right 00110, down 00100, down-left 00101, left 00001, up-left 01001.
REQ-017 Buttons, active-high before inversion: fire1 -> bit5, fire2 -> bit6, fire3 -> bit7.
REQ-018 pad_out byte SHALL equal the bitwise inverse of (direction code OR button bits); idle value is 8'hFF.
REQ-019 Autofire FSM per channel, states IDLE, ON, OFF: IDLE->ON when committed fire1=1 and autofire_en=1, with the phase counter cleared to 0.
REQ-020 In ON or OFF, the phase counter SHALL increment each cycle; at AUTOFIRE_DIV-1 it SHALL wrap to 0 and the state SHALL toggle ON<->OFF.
REQ-021 In any state, committed fire1=0 or autofire_en=0 SHALL force IDLE on the next cycle.
REQ-022 Effective fire1 SHALL be 1 in ON, 0 in OFF, and the committed fire1 in IDLE.
REQ-023 pad_chg[i] SHALL pulse high for exactly one cycle, coincident with the first cycle the new pad_out byte is visible; it SHALL not pulse on a write of an identical value.
REQ-024 Simultaneous change on all channels SHALL update every channel in the same cycle with independent pad_chg pulses.

Reset
REQ-025 While reset=1: pad_out = all 8'hFF, pad_chg = 0, synchronisers, committed states and counters = 0, all autofire FSMs = IDLE.
REQ-026 Reset asserted mid-debounce or mid-autofire SHALL abort the operation; after release, behaviour SHALL equal that from power-up, with latency measured from the first post-reset cycle.
REQ-027 pad_chg SHALL not pulse on the reset-release cycle.

Verification
REQ-028 DEBOUNCE=15: joy_in[7:0]=8'h08 held -> pad_out[7:0]=8'hF7 at exactly cycle 18, pad_chg[0] high for cycle 18 only.
REQ-029 Glitch: joy_in bit0 high for 10 cycles, then low -> pad_out stays 8'hFF, no pad_chg pulse.
REQ-030 Cancel: joy_in=8'h0F -> pad_out stays 8'hFF; joy_in=8'h0B (up, left, right) -> 8'hF7.
REQ-031 AUTOFIRE_DIV=4, autofire_en[0]=1, fire1 held -> after commit, bit5 of pad_out alternates low 4 cycles / high 4 cycles; releasing fire1 -> 8'hFF within DEBOUNCE+4 cycles.
REQ-032 swap=1, joy_in channel 0 = 8'h10 -> pad_out[15:8]=8'hDF and pad_out[7:0]=8'hFF.
REQ-033 Reset pulsed during autofire ON -> next cycle pad_out=8'hFF; with input still held, re-commit after DEBOUNCE+3 cycles and the FSM restarts in ON.
